dmem_ram: RTL and testbench

//  Simulation data memory: the slave on the core's dmem valid/ready port, replacing the dmem stub in soc_top.

---
 rtl/dmem_pkg.sv | 26 ++
 rtl/dmem_bank.sv | 32 +++
 rtl/dmem_ram.sv | 122 ++++++++++++
 tb/tb_dmem_ram.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// ============================================================================
// dmem_pkg : shared types and default address map for the data memory. Rev 1.0
// ============================================================================
`default_nettype none

package dmem_pkg;

    localparam logic [31:0] DMEM_BASE_ADDR   = 32'h0001_0000;
    localparam logic [31:0] DMEM_TOHOST_ADDR = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_e;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } dmem_req_t;

endpackage

`default_nettype wire

// File: rtl/dmem_bank.sv
// ============================================================================
// dmem_bank : word array, synchronous byte-lane write, combinational read. Rev 1.0
// ============================================================================
`default_nettype none

module dmem_bank #(
    parameter int DEPTH_WORDS = 4096,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] idx,
    input  logic [31:0]      wdata,
    input  logic [3:0]       wstrb,
    output logic [31:0]      rdata
);

    logic [31:0] r_mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we && wstrb[i]) begin
                r_mem[idx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = r_mem[idx];

endmodule

`default_nettype wire

// File: rtl/dmem_ram.sv
// ============================================================================
// dmem_ram : dmem valid/ready slave with wait states, tohost mailbox, error flag. Rev 1.0
// ============================================================================
`default_nettype none

module dmem_ram
    import dmem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 4096,
    parameter logic [31:0] BASE_ADDR   = DMEM_BASE_ADDR,
    parameter int          WAIT_CYCLES = 1,
    parameter logic [31:0] TOHOST_ADDR = DMEM_TOHOST_ADDR
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        dmem_valid_i,
    input  logic        dmem_we_i,
    input  logic [31:0] dmem_addr_i,
    input  logic [31:0] dmem_wdata_i,
    input  logic [3:0]  dmem_wstrb_i,
    output logic [31:0] dmem_rdata_o,
    output logic        dmem_ready_o,
    output logic        done_o,
    output logic [31:0] tohost_o,
    output logic        err_o
);

    localparam int          c_IDX_W  = $clog2(DEPTH_WORDS);
    localparam logic [32:0] c_RAM_LO = {1'b0, BASE_ADDR};
    localparam logic [32:0] c_RAM_HI = c_RAM_LO + 33'(4 * DEPTH_WORDS);

    dmem_state_e       r_state;
    dmem_req_t         r_req;
    logic [3:0]        r_cnt;
    logic              r_ready;
    logic              r_done;
    logic              r_err;
    logic [31:0]       r_tohost;

    logic              w_ram_hit;
    logic              w_mbox_hit;
    logic              w_bank_we;
    logic [c_IDX_W-1:0] w_idx;
    logic [31:0]       w_bank_rdata;

    // 33-bit compare so a RAM window touching the top of the address space cannot wrap
    assign w_ram_hit  = ({1'b0, r_req.addr} >= c_RAM_LO) && ({1'b0, r_req.addr} < c_RAM_HI);
    assign w_mbox_hit = (r_req.addr[31:2] == TOHOST_ADDR[31:2]);
    assign w_idx      = c_IDX_W'((r_req.addr - BASE_ADDR) >> 2);
    assign w_bank_we  = (r_state == RESP) && r_req.we && w_ram_hit && !w_mbox_hit;

    dmem_bank #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (c_IDX_W)
    ) u_bank (
        .clk   (clk_i),
        .we    (w_bank_we),
        .idx   (w_idx),
        .wdata (r_req.wdata),
        .wstrb (r_req.wstrb),
        .rdata (w_bank_rdata)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state  <= IDLE;
            r_req    <= '0;
            r_cnt    <= '0;
            r_ready  <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_tohost <= '0;
        end else begin
            r_ready <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (dmem_valid_i) begin
                        r_req <= '{we: dmem_we_i, addr: dmem_addr_i,
                                   wdata: dmem_wdata_i, wstrb: dmem_wstrb_i};
                        if (WAIT_CYCLES > 0) begin
                            r_state <= WAIT;
                            r_cnt   <= 4'(WAIT_CYCLES - 1);
                        end else begin
                            r_state <= RESP;
                            r_ready <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= RESP;
                        r_ready <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                    if (w_mbox_hit) begin
                        if (r_req.we) begin
                            r_tohost <= r_req.wdata;
                            r_done   <= 1'b1;
                        end
                    end else if (!w_ram_hit) begin
                        r_err <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // r_ready is high exactly in RESP, so it also gates the read data
    assign dmem_rdata_o = (r_ready && !r_req.we && w_ram_hit && !w_mbox_hit) ? w_bank_rdata : '0;
    assign dmem_ready_o = r_ready;
    assign done_o       = r_done;
    assign err_o        = r_err;
    assign tohost_o     = r_tohost;

endmodule

`default_nettype wire

// File: tb/tb_dmem_ram.sv
// ============================================================================
// tb_dmem_ram : directed bench driving three instances with 0, 1 and 3 wait states. Rev 1.0
// ============================================================================
`default_nettype none

module tb_dmem_ram;

    logic        clk;
    logic        rst_n;
    logic        valid  [3];
    logic        we     [3];
    logic [31:0] addr   [3];
    logic [31:0] wdata  [3];
    logic [3:0]  wstrb  [3];
    logic [31:0] rdata  [3];
    logic        ready  [3];
    logic        done   [3];
    logic [31:0] tohost [3];
    logic        err    [3];

    int n_assert = 0;
    int n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    dmem_ram #(.WAIT_CYCLES(0)) u_dut0 (
        .clk_i(clk), .rst_n_i(rst_n), .dmem_valid_i(valid[0]), .dmem_we_i(we[0]),
        .dmem_addr_i(addr[0]), .dmem_wdata_i(wdata[0]), .dmem_wstrb_i(wstrb[0]),
        .dmem_rdata_o(rdata[0]), .dmem_ready_o(ready[0]), .done_o(done[0]),
        .tohost_o(tohost[0]), .err_o(err[0]));

    dmem_ram #(.WAIT_CYCLES(1)) u_dut1 (
        .clk_i(clk), .rst_n_i(rst_n), .dmem_valid_i(valid[1]), .dmem_we_i(we[1]),
        .dmem_addr_i(addr[1]), .dmem_wdata_i(wdata[1]), .dmem_wstrb_i(wstrb[1]),
        .dmem_rdata_o(rdata[1]), .dmem_ready_o(ready[1]), .done_o(done[1]),
        .tohost_o(tohost[1]), .err_o(err[1]));

    dmem_ram #(.WAIT_CYCLES(3)) u_dut2 (
        .clk_i(clk), .rst_n_i(rst_n), .dmem_valid_i(valid[2]), .dmem_we_i(we[2]),
        .dmem_addr_i(addr[2]), .dmem_wdata_i(wdata[2]), .dmem_wstrb_i(wstrb[2]),
        .dmem_rdata_o(rdata[2]), .dmem_ready_o(ready[2]), .done_o(done[2]),
        .tohost_o(tohost[2]), .err_o(err[2]));

    function automatic int wait_of(input int k);
        return (k == 0) ? 0 : ((k == 1) ? 1 : 3);
    endfunction

    // One complete request; returns at the edge closing RESP, so the next call is back-to-back
    task automatic access(input int k, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] s,
                          input string name, output logic [31:0] rd);
        int lat;
        @(negedge clk);
        valid[k] = 1'b1; we[k] = w; addr[k] = a; wdata[k] = d; wstrb[k] = s;
        @(posedge clk); #1;
        valid[k] = 1'b0; addr[k] = 32'hFFFF_FFF0; wdata[k] = ~d; wstrb[k] = 4'hF; we[k] = ~w;
        lat = 1;
        while (ready[k] !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        rd = rdata[k];
        n_assert++;
        if (lat !== wait_of(k) + 1) begin
            n_fail++;
            $display("FAIL %s[w%0d] latency: got %0d cycles, want %0d", name, wait_of(k), lat, wait_of(k) + 1);
        end
        @(posedge clk); #1;
        we[k] = 1'b0; addr[k] = '0; wdata[k] = '0; wstrb[k] = '0;
        n_assert++;
        if (ready[k] !== 1'b0 || rdata[k] !== 32'h0) begin
            n_fail++;
            $display("FAIL %s[w%0d] pulse: ready=%b rdata=%h after RESP, want 0/0", name, wait_of(k), ready[k], rdata[k]);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            valid[k] = 1'b0; we[k] = 1'b0; addr[k] = '0; wdata[k] = '0; wstrb[k] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            n_assert++;
            if (ready[k] !== 1'b0 || rdata[k] !== 32'h0 || done[k] !== 1'b0 ||
                err[k] !== 1'b0 || tohost[k] !== 32'h0) begin
                n_fail++;
                $display("FAIL reset[%0d]: ready=%b rdata=%h done=%b err=%b tohost=%h, want all 0",
                         k, ready[k], rdata[k], done[k], err[k], tohost[k]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic(input int k);
        logic [31:0] rd;
        access(k, 1'b1, 32'h0001_0010, 32'hDEAD_BEEF, 4'hF, "basic_wr", rd);
        access(k, 1'b0, 32'h0001_0010, 32'h0, 4'h0, "basic_rd", rd);
        n_assert++;
        if (rd !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL basic_rdata[%0d]: got %h, want deadbeef", k, rd);
        end
    endtask

    task automatic test_byte_lanes(input int k);
        logic [31:0] rd;
        access(k, 1'b1, 32'h0001_0010, 32'h0000_AA00, 4'b0010, "lane_wr", rd);
        access(k, 1'b0, 32'h0001_0010, 32'h0, 4'h0, "lane_rd", rd);
        n_assert++;
        if (rd !== 32'hDEAD_AAEF) begin
            n_fail++;
            $display("FAIL lane_rdata[%0d]: got %h, want deadaaef", k, rd);
        end
        access(k, 1'b1, 32'h0001_0010, 32'hFFFF_FFFF, 4'b0000, "nostrb_wr", rd);
        access(k, 1'b0, 32'h0001_0010, 32'h0, 4'h0, "nostrb_rd", rd);
        n_assert++;
        if (rd !== 32'hDEAD_AAEF) begin
            n_fail++;
            $display("FAIL nostrb_rdata[%0d]: got %h, want deadaaef", k, rd);
        end
    endtask

    task automatic test_bounds(input int k);
        logic [31:0] rd;
        access(k, 1'b1, 32'h0001_3FFC, 32'hCAFE_F00D, 4'hF, "top_wr", rd);
        access(k, 1'b0, 32'h0001_3FFC, 32'h0, 4'h0, "top_rd", rd);
        n_assert++;
        if (rd !== 32'hCAFE_F00D || err[k] !== 1'b0) begin
            n_fail++;
            $display("FAIL top_word: rdata=%h err=%b, want cafef00d/0", rd, err[k]);
        end
        access(k, 1'b0, 32'h0001_4000, 32'h0, 4'h0, "past_end_rd", rd);
        n_assert++;
        if (rd !== 32'h0 || err[k] !== 1'b1) begin
            n_fail++;
            $display("FAIL past_end: rdata=%h err=%b, want 0/1", rd, err[k]);
        end
        access(k, 1'b1, 32'h0000_FFFC, 32'h1234_5678, 4'hF, "below_wr", rd);
        access(k, 1'b1, 32'h0001_4010, 32'h0BAD_0BAD, 4'hF, "above_wr", rd);
        n_assert++;
        if (err[k] !== 1'b1) begin
            n_fail++;
            $display("FAIL miss_err_sticky: err=%b, want 1", err[k]);
        end
        access(k, 1'b0, 32'h0001_3FFC, 32'h0, 4'h0, "alias_top_rd", rd);
        n_assert++;
        if (rd !== 32'hCAFE_F00D) begin
            n_fail++;
            $display("FAIL dropped_write_top: got %h, want cafef00d", rd);
        end
        access(k, 1'b0, 32'h0001_0010, 32'h0, 4'h0, "alias_low_rd", rd);
        n_assert++;
        if (rd !== 32'hDEAD_AAEF) begin
            n_fail++;
            $display("FAIL dropped_write_low: got %h, want deadaaef", rd);
        end
    endtask

    task automatic test_mailbox(input int k);
        logic [31:0] rd;
        access(k, 1'b1, 32'h8000_0000, 32'h0000_0001, 4'hF, "tohost_wr1", rd);
        n_assert++;
        if (done[k] !== 1'b1 || tohost[k] !== 32'h1) begin
            n_fail++;
            $display("FAIL tohost_first: done=%b tohost=%h, want 1/00000001", done[k], tohost[k]);
        end
        access(k, 1'b1, 32'h8000_0000, 32'h0000_0003, 4'h0, "tohost_wr2", rd);
        n_assert++;
        if (done[k] !== 1'b1 || tohost[k] !== 32'h3) begin
            n_fail++;
            $display("FAIL tohost_second: done=%b tohost=%h, want 1/00000003", done[k], tohost[k]);
        end
        access(k, 1'b0, 32'h8000_0000, 32'h0, 4'h0, "tohost_rd", rd);
        n_assert++;
        if (rd !== 32'h0 || err[k] !== 1'b0) begin
            n_fail++;
            $display("FAIL tohost_read: rdata=%h err=%b, want 0/0", rd, err[k]);
        end
    endtask

    task automatic test_back_to_back(input int k);
        logic [31:0] rd;
        access(k, 1'b1, 32'h0001_0100, 32'h0102_0304, 4'hF, "b2b_wr0", rd);
        access(k, 1'b1, 32'h0001_0104, 32'hA0B0_C0D0, 4'hF, "b2b_wr1", rd);
        access(k, 1'b0, 32'h0001_0100, 32'h0, 4'h0, "b2b_rd0", rd);
        n_assert++;
        if (rd !== 32'h0102_0304) begin
            n_fail++;
            $display("FAIL b2b_word0[%0d]: got %h, want 01020304", k, rd);
        end
        access(k, 1'b0, 32'h0001_0104, 32'h0, 4'h0, "b2b_rd1", rd);
        n_assert++;
        if (rd !== 32'hA0B0_C0D0 || err[k] !== 1'b0 || done[k] !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_word1[%0d]: rdata=%h err=%b done=%b, want a0b0c0d0/0/0", k, rd, err[k], done[k]);
        end
    endtask

    task automatic test_reset_mid_write(input int k);
        logic [31:0] rd;
        logic        seen;
        access(k, 1'b1, 32'h0001_0020, 32'h1122_3344, 4'hF, "pre_wr", rd);
        @(negedge clk);
        valid[k] = 1'b1; we[k] = 1'b1; addr[k] = 32'h0001_0020;
        wdata[k] = 32'h5566_7788; wstrb[k] = 4'hF;
        @(posedge clk); #1;
        valid[k] = 1'b0; we[k] = 1'b0; addr[k] = '0; wdata[k] = '0; wstrb[k] = '0;
        rst_n = 1'b0;
        seen = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            seen = seen | ready[k];
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            seen = seen | ready[k];
        end
        n_assert++;
        if (seen !== 1'b0 || err[k] !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_no_ready: ready_seen=%b err=%b, want 0/0", seen, err[k]);
        end
        access(k, 1'b0, 32'h0001_0020, 32'h0, 4'h0, "post_rd", rd);
        n_assert++;
        if (rd !== 32'h1122_3344) begin
            n_fail++;
            $display("FAIL abort_no_commit: got %h, want 11223344", rd);
        end
    endtask

    initial begin
        test_reset();
        for (int k = 0; k < 3; k++) begin
            test_basic(k);
            test_byte_lanes(k);
        end
        test_bounds(1);
        test_mailbox(0);
        test_back_to_back(2);
        test_reset_mid_write(1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
